// File: rtl/u_rx.sv
// UART receiver: two-flop line synchronizer, oversampled start/data/stop sampling,
// registered parallel word with a one-cycle done strobe and framing-error flag.
module u_rx #(
    parameter int width        = 8,
    parameter int no_of_sample = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_in,
    input  logic             baud_en_rx,
    output logic [width-1:0] rx_data_out,
    output logic             rx_done,
    output logic             rx_active,
    output logic             frame_err
);
    localparam int TW = $clog2(no_of_sample);
    localparam int BW = (width > 1) ? $clog2(width) : 1;
    localparam logic [TW-1:0] HALF_LAST = TW'(no_of_sample / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(no_of_sample - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(32'd1);
    localparam logic [BW-1:0] LAST_IDX  = BW'(width - 1);
    localparam logic [BW-1:0] IDX_ONE   = BW'(32'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t           state_r, state_s;
    logic             sync1_r;
    logic             rx_s;
    logic [TW-1:0]    tick_cnt_r, tick_cnt_s;
    logic [BW-1:0]    bit_idx_r, bit_idx_s;
    logic [width-1:0] shreg_r, shreg_s;
    logic [width-1:0] rx_data_r, rx_data_s;
    logic             frame_err_r, frame_err_s;
    logic             rx_done_r, rx_done_s;
    logic             rx_active_r;

    // Next-state, counter and output-capture logic
    always_comb begin
        state_s     = state_r;
        tick_cnt_s  = tick_cnt_r;
        bit_idx_s   = bit_idx_r;
        shreg_s     = shreg_r;
        rx_data_s   = rx_data_r;
        frame_err_s = frame_err_r;
        rx_done_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                tick_cnt_s = '0;
                bit_idx_s  = '0;
                if (baud_en_rx && !rx_s) begin
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_en_rx) begin
                    if (tick_cnt_r == HALF_LAST) begin
                        tick_cnt_s = '0;
                        // A high line at mid start bit was only a glitch
                        if (!rx_s) begin
                            state_s = ST_DATA;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        tick_cnt_s = tick_cnt_r + TICK_ONE;
                    end
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (baud_en_rx) begin
                    if (tick_cnt_r == FULL_LAST) begin
                        tick_cnt_s         = '0;
                        shreg_s[bit_idx_r] = rx_s;
                        if (bit_idx_r == LAST_IDX) begin
                            state_s = ST_STOP;
                        end else begin
                            bit_idx_s = bit_idx_r + IDX_ONE;
                        end
                    end else begin
                        tick_cnt_s = tick_cnt_r + TICK_ONE;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (baud_en_rx) begin
                    if (tick_cnt_r == FULL_LAST) begin
                        // Leaving at mid stop bit lets the next start bit follow directly
                        tick_cnt_s  = '0;
                        rx_data_s   = shreg_r;
                        frame_err_s = ~rx_s;
                        rx_done_s   = 1'b1;
                        state_s     = ST_IDLE;
                    end else begin
                        tick_cnt_s = tick_cnt_r + TICK_ONE;
                    end
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                tick_cnt_s = '0;
                bit_idx_s  = '0;
            end
        endcase
    end

    // Synchronizer, FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r     <= 1'b1;
            rx_s        <= 1'b1;
            state_r     <= ST_IDLE;
            tick_cnt_r  <= '0;
            bit_idx_r   <= '0;
            shreg_r     <= '0;
            rx_data_r   <= '0;
            frame_err_r <= 1'b0;
            rx_done_r   <= 1'b0;
            rx_active_r <= 1'b0;
        end else begin
            sync1_r     <= rx_in;
            rx_s        <= sync1_r;
            state_r     <= state_s;
            tick_cnt_r  <= tick_cnt_s;
            bit_idx_r   <= bit_idx_s;
            shreg_r     <= shreg_s;
            rx_data_r   <= rx_data_s;
            frame_err_r <= frame_err_s;
            rx_done_r   <= rx_done_s;
            rx_active_r <= (state_s != ST_IDLE);
        end
    end

    assign rx_data_out = rx_data_r;
    assign rx_done     = rx_done_r;
    assign rx_active   = rx_active_r;
    assign frame_err   = frame_err_r;

endmodule

// File: tb/tb_u_rx.sv
// Bench for u_rx: a tick-offset frame model checked every cycle, plus directed
// frame scenarios with hand-computed words, pulse counts and sample timing.
module tb_u_rx;
    logic       clk;
    logic       rst;
    logic       rx_a, rx_b;
    logic       tick_a, tick_b;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       done_a, act_a, err_a;
    logic       done_b, act_b, err_b;

    int vectors     = 0;
    int miscompares = 0;
    int nprint      = 0;
    int cyc         = 0;
    bit cmp_en      = 1'b0;

    int   done_cnt_a = 0, done_cnt_b = 0;
    int   span_a = 0, span_b = 0, last_span_a = 0, last_span_b = 0;
    logic prev_act_a = 1'b0, prev_act_b = 1'b0;
    logic last_err_a = 1'b0, last_err_b = 1'b0;
    logic [7:0] words_a[$];
    int         times_a[$];
    logic [6:0] last_word_b = 7'd0;

    typedef struct packed {
        logic        d1;
        logic        d2;
        logic        busy;
        logic [31:0] ticks;
        logic [7:0]  bits;
        logic [7:0]  data;
        logic        err;
        logic        done;
        logic        active;
    } model_t;

    model_t m_a, m_b;

    u_rx #(.width(8), .no_of_sample(16)) dut_a (
        .clk(clk), .rst(rst), .rx_in(rx_a), .baud_en_rx(tick_a),
        .rx_data_out(data_a), .rx_done(done_a), .rx_active(act_a), .frame_err(err_a)
    );

    u_rx #(.width(7), .no_of_sample(8)) dut_b (
        .clk(clk), .rst(rst), .rx_in(rx_b), .baud_en_rx(tick_b),
        .rx_data_out(data_b), .rx_done(done_b), .rx_active(act_b), .frame_err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame model: once a start is seen, every sample is a fixed tick offset
    // from the detection tick (start at n/2, bit k at n/2+(k+1)n, stop at n/2+(w+1)n).
    function automatic model_t step_model(model_t m, logic rx, logic tick, logic r, int n_s, int w);
        model_t n;
        int     t;
        n      = m;
        n.done = 1'b0;
        if (r) begin
            n    = '0;
            n.d1 = 1'b1;
            n.d2 = 1'b1;
            return n;
        end
        if (tick) begin
            if (!m.busy) begin
                if (m.d2 == 1'b0) begin
                    n.busy  = 1'b1;
                    n.ticks = 32'd0;
                end
            end else begin
                t       = int'(m.ticks) + 1;
                n.ticks = t;
                if (t == n_s / 2 && m.d2 == 1'b1) n.busy = 1'b0;
                for (int k = 0; k < w; k++)
                    if (t == n_s / 2 + (k + 1) * n_s) n.bits[k] = m.d2;
                if (t == n_s / 2 + (w + 1) * n_s) begin
                    n.data = n.bits;
                    n.err  = ~m.d2;
                    n.done = 1'b1;
                    n.busy = 1'b0;
                end
            end
        end
        n.active = n.busy;
        n.d2     = m.d1;
        n.d1     = rx;
        return n;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            m_a = step_model(m_a, rx_a, tick_a, rst, 16, 8);
            m_b = step_model(m_b, rx_b, tick_b, rst, 8, 7);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                vectors++;
                if ({data_a, done_a, act_a, err_a} !== {m_a.data, m_a.done, m_a.active, m_a.err}) begin
                    miscompares++;
                    if (nprint < 20)
                        $display("FAIL cycle_a t=%0t data=%h/%h done=%b/%b active=%b/%b err=%b/%b (got/want)",
                                 $time, data_a, m_a.data, done_a, m_a.done, act_a, m_a.active, err_a, m_a.err);
                    nprint++;
                end
                vectors++;
                if ({data_b, done_b, act_b, err_b} !== {m_b.data[6:0], m_b.done, m_b.active, m_b.err}) begin
                    miscompares++;
                    if (nprint < 20)
                        $display("FAIL cycle_b t=%0t data=%h/%h done=%b/%b active=%b/%b err=%b/%b (got/want)",
                                 $time, data_b, m_b.data[6:0], done_b, m_b.done, act_b, m_b.active, err_b, m_b.err);
                    nprint++;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: record what the edge just produced, then drive the next inputs.
    task automatic step(input logic a, input logic b, input logic r);
        @(negedge clk);
        if (tick_a && prev_act_a) span_a++;
        if (!prev_act_a && act_a) span_a = 0;
        prev_act_a = act_a;
        if (tick_b && prev_act_b) span_b++;
        if (!prev_act_b && act_b) span_b = 0;
        prev_act_b = act_b;
        if (done_a === 1'b1) begin
            done_cnt_a++;
            words_a.push_back(data_a);
            times_a.push_back(cyc);
            last_err_a  = err_a;
            last_span_a = span_a;
        end
        if (done_b === 1'b1) begin
            done_cnt_b++;
            last_word_b = data_b;
            last_err_b  = err_b;
            last_span_b = span_b;
        end
        rx_a   = a;
        rx_b   = b;
        rst    = r;
        tick_b = (cyc % 5 == 0);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0);
    endtask

    task automatic send_frame(input bit on_b, input logic [7:0] d, input int nbits,
                              input int blen, input logic stop, input int rst_at);
        int   c;
        logic v;
        logic r;
        c = 0;
        for (int i = 0; i < nbits + 2; i++) begin
            if (i == 0) v = 1'b0;
            else if (i == nbits + 1) v = stop;
            else v = d[i-1];
            for (int j = 0; j < blen; j++) begin
                r = (rst_at >= 0 && c >= rst_at && c < rst_at + 2);
                if (on_b) step(1'b1, v, r);
                else step(v, 1'b1, r);
                c++;
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        rx_a   = 1'b1;
        rx_b   = 1'b1;
        tick_a = 1'b1;
        tick_b = 1'b0;
        repeat (3) step(1'b1, 1'b1, 1'b1);
        cmp_en = 1'b1;
        chk("reset_data", 32'(data_a), 32'h0);
        chk("reset_done", 32'(done_a), 32'h0);
        chk("reset_active", 32'(act_a), 32'h0);
        chk("reset_err", 32'(err_a), 32'h0);
        idle(10);

        // Clean frame 0xA5, tick every cycle
        send_frame(1'b0, 8'hA5, 8, 16, 1'b1, -1);
        idle(20);
        chk("a5_count", 32'(done_cnt_a), 32'd1);
        chk("a5_data", 32'(data_a), 32'hA5);
        chk("a5_err", 32'(last_err_a), 32'h0);
        chk("a5_stop_tick", 32'(last_span_a), 32'd152);

        // Four-cycle glitch: false start, nothing changes
        repeat (4) step(1'b0, 1'b1, 1'b0);
        idle(40);
        chk("glitch_count", 32'(done_cnt_a), 32'd1);
        chk("glitch_data", 32'(data_a), 32'hA5);
        chk("glitch_active", 32'(act_a), 32'h0);

        // Bad stop bit, then a good frame clears the flag
        send_frame(1'b0, 8'h3C, 8, 16, 1'b0, -1);
        idle(40);
        chk("badstop_count", 32'(done_cnt_a), 32'd2);
        chk("badstop_data", 32'(data_a), 32'h3C);
        chk("badstop_err", 32'(last_err_a), 32'h1);
        send_frame(1'b0, 8'h01, 8, 16, 1'b1, -1);
        idle(20);
        chk("good_count", 32'(done_cnt_a), 32'd3);
        chk("good_data", 32'(data_a), 32'h01);
        chk("good_err", 32'(err_a), 32'h0);

        // Back-to-back frames, no idle gap: pulses exactly one frame apart
        send_frame(1'b0, 8'h55, 8, 16, 1'b1, -1);
        send_frame(1'b0, 8'hAA, 8, 16, 1'b1, -1);
        idle(20);
        chk("b2b_count", 32'(done_cnt_a), 32'd5);
        if (done_cnt_a == 5) begin
            chk("b2b_first", 32'(words_a[3]), 32'h55);
            chk("b2b_second", 32'(words_a[4]), 32'hAA);
            chk("b2b_spacing", 32'(times_a[4] - times_a[3]), 32'd160);
        end

        // Reset during data bit 3 of 0xFF aborts it; then a clean 0x12
        send_frame(1'b0, 8'hFF, 8, 16, 1'b1, 69);
        idle(20);
        chk("abort_count", 32'(done_cnt_a), 32'd5);
        chk("abort_data", 32'(data_a), 32'h0);
        chk("abort_err", 32'(err_a), 32'h0);
        chk("abort_active", 32'(act_a), 32'h0);
        send_frame(1'b0, 8'h12, 8, 16, 1'b1, -1);
        idle(20);
        chk("after_abort_count", 32'(done_cnt_a), 32'd6);
        chk("after_abort_data", 32'(data_a), 32'h12);
        chk("model_pin_a", 32'(m_a.data), 32'h12);

        // Tick every 5th cycle, 8 samples/bit, 7-bit word 0x5A (bit = 40 clocks)
        send_frame(1'b1, 8'h5A, 7, 40, 1'b1, -1);
        idle(100);
        chk("b_count", 32'(done_cnt_b), 32'd1);
        chk("b_data", 32'(last_word_b), 32'h5A);
        chk("b_err", 32'(last_err_b), 32'h0);
        chk("b_stop_tick", 32'(last_span_b), 32'd68);
        chk("model_pin_b", 32'(m_b.data[6:0]), 32'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
